// File: rtl/character_motion_engine_if.sv
// Handshake and motion bus between the collision checker,
// the motion engine and drawCharacter.
interface character_motion_engine_if #(
    parameter int POS_W = 8,
    parameter int VEL_W = 6
);
    logic             enable;
    logic [POS_W-1:0] y_position_in;
    logic             jump;
    logic             up_blocked;
    logic             down_blocked;
    logic [POS_W-1:0] x_position;
    logic [POS_W-1:0] y_position;
    logic [VEL_W-1:0] velocity;
    logic             airborne;
    logic             done;

    modport master (
        output enable, y_position_in, jump,
        output up_blocked, down_blocked,
        input  x_position, y_position, velocity,
        input  airborne, done
    );

    modport slave (
        input  enable, y_position_in, jump,
        input  up_blocked, down_blocked,
        output x_position, y_position, velocity,
        output airborne, done
    );
endinterface

// File: rtl/character_motion_engine.sv
// Per-frame vertical motion: gravity, jump impulse,
// tile collision response and screen clamping.
module character_motion_engine #(
    parameter int POS_W    = 8,
    parameter int VEL_W    = 6,
    parameter int X_POS    = 72,
    parameter int START_Y  = 0,
    parameter int FLOOR_Y  = 103,
    parameter int CEIL_Y   = 0,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 4,
    parameter int JUMP_V0  = 6
) (
    input logic clock,
    input logic resetn,
    character_motion_engine_if.slave bus
);
    localparam int VW1 = VEL_W + 1;
    localparam int PW2 = POS_W + 2;

    localparam logic signed [VW1-1:0] GRAV_S = VW1'(GRAVITY);
    localparam logic signed [VW1-1:0] MAXF_S = VW1'(MAX_FALL);
    localparam logic signed [VW1-1:0] JUMP_S = -VW1'(JUMP_V0);
    localparam logic signed [PW2-1:0] FLR_S  = PW2'(FLOOR_Y);
    localparam logic signed [PW2-1:0] CEIL_S = PW2'(CEIL_Y);

    typedef enum logic [1:0] {
        WAIT, CALC, COMMIT, DONE
    } state_t;

    state_t state, state_nxt;

    logic             latch_en;
    logic             commit_en;
    logic [POS_W-1:0] y_lat;
    logic [VEL_W-1:0] vy_lat;
    logic [POS_W-1:0] y_reg;
    logic [VEL_W-1:0] vel_reg;
    logic             air_reg;

    logic signed [VW1-1:0] vel_ext;
    logic signed [VW1-1:0] vy_sum;
    logic signed [VW1-1:0] vy_c;
    logic signed [VW1-1:0] vy_calc;

    logic signed [PW2-1:0] y_ext;
    logic signed [PW2-1:0] vy_ext;
    logic signed [PW2-1:0] y_sum;
    logic [POS_W-1:0]      y_commit;
    logic [VEL_W-1:0]      v_commit;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT:    if (bus.enable) state_nxt = CALC;
            CALC:    state_nxt = COMMIT;
            COMMIT:  state_nxt = DONE;
            DONE:    if (!bus.enable) state_nxt = WAIT;
            default: state_nxt = WAIT;
        endcase
    end

    always_comb begin
        latch_en  = (state == CALC);
        commit_en = (state == COMMIT);
        bus.done  = (state == DONE);
    end

    // Velocity rules; later collision checks override gravity.
    always_comb begin
        vel_ext = {vel_reg[VEL_W-1], vel_reg};
        vy_sum  = vel_ext + GRAV_S;
        vy_c    = (vy_sum > MAXF_S) ? MAXF_S : vy_sum;
        vy_calc = vy_c;
        if (bus.jump && bus.down_blocked && !vel_reg[VEL_W-1]) begin
            vy_calc = JUMP_S;
        end else if (bus.up_blocked && vy_c < 0) begin
            vy_calc = '0;
        end else if (bus.down_blocked && vy_c > 0) begin
            vy_calc = '0;
        end
    end

    // Position is summed two bits wider so screen edges never wrap.
    always_comb begin
        y_ext    = {2'b00, y_lat};
        vy_ext   = {{(PW2-VEL_W){vy_lat[VEL_W-1]}}, vy_lat};
        y_sum    = y_ext + vy_ext;
        y_commit = y_sum[POS_W-1:0];
        v_commit = vy_lat;
        if (y_sum > FLR_S) begin
            y_commit = FLR_S[POS_W-1:0];
            v_commit = '0;
        end else if (y_sum < CEIL_S) begin
            y_commit = CEIL_S[POS_W-1:0];
            v_commit = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            y_lat   <= '0;
            vy_lat  <= '0;
            y_reg   <= POS_W'(START_Y);
            vel_reg <= '0;
            air_reg <= 1'b0;
        end else begin
            if (latch_en) begin
                y_lat  <= bus.y_position_in;
                vy_lat <= vy_calc[VEL_W-1:0];
            end
            if (commit_en) begin
                y_reg   <= y_commit;
                vel_reg <= v_commit;
                air_reg <= (v_commit != '0);
            end
        end
    end

    assign bus.x_position = POS_W'(X_POS);
    assign bus.y_position = y_reg;
    assign bus.velocity   = vel_reg;
    assign bus.airborne   = air_reg;
endmodule

// File: tb/tb_character_motion_engine.sv
// Directed bench for the motion engine: frames,
// clamping, handshake timing and async reset.
module tb_character_motion_engine;
    logic clock;
    logic resetn;
    int   n_chk;
    int   n_fail;

    character_motion_engine_if #(.POS_W(8), .VEL_W(6)) bus ();

    character_motion_engine dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got,
                       input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic frame(input int y, input logic j,
                         input logic u, input logic d);
        int k;
        @(negedge clock);
        bus.y_position_in = 8'(y);
        bus.jump          = j;
        bus.up_blocked    = u;
        bus.down_blocked  = d;
        bus.enable        = 1'b1;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!bus.done && k < 10);
        chk("frame_done", int'(bus.done), 1);
        bus.enable = 1'b0;
        @(negedge clock);
    endtask

    task automatic expect_st(input string tag, input int y,
                             input int v, input int a);
        chk({tag, "_y"}, int'(bus.y_position), y);
        chk({tag, "_v"}, int'($signed(bus.velocity)), v);
        chk({tag, "_air"}, int'(bus.airborne), a);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        resetn = 1'b0;
        bus.enable        = 1'b0;
        bus.y_position_in = '0;
        bus.jump          = 1'b0;
        bus.up_blocked    = 1'b0;
        bus.down_blocked  = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_x", int'(bus.x_position), 72);
        chk("rst_done", int'(bus.done), 0);
        expect_st("rst", 0, 0, 0);
        resetn = 1'b1;

        frame(50, 0, 0, 0); expect_st("fall1", 51, 1, 1);
        frame(51, 0, 0, 0); expect_st("fall2", 53, 2, 1);
        frame(53, 0, 0, 0); expect_st("fall3", 56, 3, 1);
        frame(56, 0, 0, 0); expect_st("fall4", 60, 4, 1);
        frame(60, 0, 0, 0); expect_st("fall_sat", 64, 4, 1);

        frame(103, 1, 0, 1); expect_st("jump", 97, -6, 1);
        frame(97, 0, 0, 0);  expect_st("rise", 92, -5, 1);

        frame(60, 0, 1, 0); expect_st("bump", 60, 0, 0);
        frame(60, 0, 0, 0); expect_st("bump_nx", 61, 1, 1);

        frame(61, 0, 0, 0); frame(63, 0, 0, 0);
        frame(66, 0, 0, 0); expect_st("pre_flr", 70, 4, 1);
        frame(101, 0, 0, 0); expect_st("floor", 103, 0, 0);

        frame(103, 1, 0, 1); expect_st("jump2", 97, -6, 1);
        frame(3, 0, 0, 0);   expect_st("ceil", 0, 0, 0);

        @(negedge clock);
        bus.y_position_in = 8'd10;
        bus.enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 10) bus.y_position_in = 8'd20;
            if (i <= 2) chk("hold_lo", int'(bus.done), 0);
            if (i == 3 || i == 9) chk("hold_hi", int'(bus.done), 1);
            if (i == 2) bus.y_position_in = 8'd40;
        end
        bus.enable = 1'b0;
        @(negedge clock);
        chk("hold_fall", int'(bus.done), 0);
        expect_st("hold", 11, 1, 1);
        repeat (2) @(negedge clock);
        chk("hold_one", int'(bus.y_position), 11);

        bus.y_position_in = 8'd11;
        bus.enable = 1'b1;
        @(negedge clock);
        bus.enable = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            @(negedge clock);
            chk("pulse_done", int'(bus.done), (i == 3) ? 1 : 0);
        end
        expect_st("pulse", 13, 2, 1);

        bus.y_position_in = 8'd40;
        bus.enable = 1'b1;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("rst_cm_done", int'(bus.done), 0);
        expect_st("rst_cm", 0, 0, 0);
        bus.enable = 1'b0;
        @(negedge clock);
        @(negedge clock);
        expect_st("rst_hold", 0, 0, 0);
        resetn = 1'b1;
        frame(0, 0, 0, 0); expect_st("post_rst", 1, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d",
                 n_chk, n_fail);
        $finish;
    end
endmodule
